// File: rtl/johnson_decoder_if.sv
// Bus bundle between a Johnson-code source (master) and johnson_decoder (slave).
interface johnson_decoder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = 3
);
  logic [WIDTH-1:0] code_in;
  logic             code_valid;
  logic [IDX_W-1:0] index;
  logic             index_valid;
  logic             illegal_code;
  logic             seq_error;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output code_in, code_valid,
    input  index, index_valid, illegal_code, seq_error, locked, err_count
  );

  modport slave (
    input  code_in, code_valid,
    output index, index_valid, illegal_code, seq_error, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson-code receive decoder: 2-stage pipeline, legality/step checks and lock FSM.
// Optional saturating total-error counter built when JOHNSON_DECODER_ERR_COUNT_EN is defined.
module johnson_decoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_ERRS   = 2,
  parameter int unsigned ALLOW_HOLD = 1
) (
  input logic              clk,
  input logic              reset,
  johnson_decoder_if.slave bus
);
  localparam int unsigned SEQ_LEN = 2 * WIDTH;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]  ERRS_N  = 4'(MAX_ERRS);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  logic [WIDTH-1:0] code_q;
  logic             vld_q;
  state_e           state_q;
  logic [IDX_W-1:0] ref_q;
  logic [IDX_W-1:0] index_q;
  logic [3:0]       good_cnt_q;
  logic [3:0]       err_run_q;
  logic             index_valid_q;
  logic             illegal_q;
  logic             seq_err_q;
  logic             locked_q;

  logic [IDX_W:0]   trans;
  logic [IDX_W:0]   ones;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] ref_inc;
  logic             legal;
  logic             step_ok;
  logic             bad_code;
  logic             bad_step;
  logic             good_step;

  always_comb begin
    trans = '0;
    ones  = '0;
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      if (code_q[i] != code_q[i+1]) trans = trans + 1'b1;
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + {{IDX_W{1'b0}}, code_q[i]};
    end
    legal = (trans <= (IDX_W+1)'(1));
    // Rising half of the ring (LSB set, or all zeros) counts ones; falling half counts back from 2*WIDTH.
    if (code_q[0] || (code_q == '0)) dec_idx = ones[IDX_W-1:0];
    else                             dec_idx = IDX_W'(SEQ_LEN - 32'(ones));
    ref_inc   = (32'(ref_q) == SEQ_LEN - 1) ? '0 : ref_q + 1'b1;
    step_ok   = (dec_idx == ref_inc) || ((ALLOW_HOLD != 0) && (dec_idx == ref_q));
    bad_code  = vld_q && !legal;
    bad_step  = vld_q && legal && (state_q != UNLOCKED) && !step_ok;
    good_step = vld_q && legal && !bad_step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q        <= '0;
      vld_q         <= 1'b0;
      state_q       <= UNLOCKED;
      ref_q         <= '0;
      index_q       <= '0;
      good_cnt_q    <= '0;
      err_run_q     <= '0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      code_q        <= bus.code_in;
      vld_q         <= bus.code_valid;
      index_valid_q <= vld_q && legal;
      illegal_q     <= bad_code;
      seq_err_q     <= bad_step;
      if (vld_q && legal) begin
        index_q <= dec_idx;
        ref_q   <= dec_idx;
      end
      unique case (state_q)
        UNLOCKED: begin
          if (good_step) begin
            good_cnt_q <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q  <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (bad_code) begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
          end else if (bad_step) begin
            good_cnt_q <= 4'd1;
          end else if (good_step) begin
            good_cnt_q <= good_cnt_q + 4'd1;
            if (4'(good_cnt_q + 4'd1) == LOCK_N) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (bad_code || bad_step) begin
            if (4'(err_run_q + 4'd1) == ERRS_N) begin
              state_q    <= UNLOCKED;
              locked_q   <= 1'b0;
              err_run_q  <= '0;
              good_cnt_q <= '0;
            end else begin
              err_run_q  <= err_run_q + 4'd1;
            end
          end else if (good_step) begin
            err_run_q <= '0;
          end
        end
        default: begin
          state_q  <= UNLOCKED;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef JOHNSON_DECODER_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if ((bad_code || bad_step) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif

  assign bus.index        = index_q;
  assign bus.index_valid  = index_valid_q;
  assign bus.illegal_code = illegal_q;
  assign bus.seq_error    = seq_err_q;
  assign bus.locked       = locked_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: directed table, corner sequences, random vs reference model.
module tb_johnson_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] cur_code = '0;
  logic       cur_valid = 1'b0;

  always #5 clk = ~clk;

  johnson_decoder_if #(.WIDTH(4), .IDX_W(3)) bus_h ();
  johnson_decoder_if #(.WIDTH(4), .IDX_W(3)) bus_n ();

  johnson_decoder #(.WIDTH(4), .IDX_W(3), .LOCK_COUNT(4), .MAX_ERRS(2), .ALLOW_HOLD(1)) dut_h (
    .clk(clk), .reset(rst), .bus(bus_h)
  );
  johnson_decoder #(.WIDTH(4), .IDX_W(3), .LOCK_COUNT(4), .MAX_ERRS(2), .ALLOW_HOLD(0)) dut_n (
    .clk(clk), .reset(rst), .bus(bus_n)
  );

  assign bus_h.code_in    = cur_code;
  assign bus_h.code_valid = cur_valid;
  assign bus_n.code_in    = cur_code;
  assign bus_n.code_valid = cur_valid;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: index 0 allows holds, index 1 does not. States: 0 unlocked, 1 acquire, 2 locked.
  int m_st[2], m_good[2], m_err[2], m_ref[2];
  int e_idx[2], e_iv[2], e_ill[2], e_seq[2], e_lock[2], e_cnt[2];
  logic [3:0] pend_code = '0;
  logic       pend_valid = 1'b0;

  function automatic logic [3:0] jcode(int p);
    logic [3:0] all1;
    all1 = 4'hF;
    if (p <= 4) return 4'((1 << p) - 1);
    return 4'(all1 << (p - 4));
  endfunction

  function automatic int jpos(logic [3:0] c);
    for (int k = 0; k < 8; k++) if (jcode(k) == c) return k;
    return -1;
  endfunction

  task automatic model_reset(int m);
    m_st[m] = 0; m_good[m] = 0; m_err[m] = 0; m_ref[m] = 0;
    e_idx[m] = 0; e_iv[m] = 0; e_ill[m] = 0; e_seq[m] = 0; e_lock[m] = 0; e_cnt[m] = 0;
  endtask

  task automatic model_bump(int m);
`ifdef JOHNSON_DECODER_ERR_COUNT_EN
    if (e_cnt[m] < 255) e_cnt[m]++;
`endif
  endtask

  task automatic model_error(int m);
    model_bump(m);
    if (m_st[m] == 2) begin
      m_err[m]++;
      if (m_err[m] == 2) begin m_st[m] = 0; m_err[m] = 0; end
    end
  endtask

  task automatic model_step(int m, logic v, logic [3:0] c);
    int p;
    bit ok;
    e_iv[m] = 0; e_ill[m] = 0; e_seq[m] = 0;
    if (v) begin
      p = jpos(c);
      if (p < 0) begin
        e_ill[m] = 1;
        if (m_st[m] == 1) m_st[m] = 0;
        else model_error(m);
        if (m_st[m] == 0) m_good[m] = 0;
      end else begin
        ok = (p == (m_ref[m] + 1) % 8) || (m == 0 && p == m_ref[m]);
        e_idx[m] = p;
        e_iv[m]  = 1;
        if (m_st[m] == 0) begin
          m_good[m] = 1; m_st[m] = 1;
        end else if (!ok) begin
          e_seq[m] = 1;
          if (m_st[m] == 1) m_good[m] = 1;
          else model_error(m);
        end else if (m_st[m] == 1) begin
          m_good[m]++;
          if (m_good[m] == 4) m_st[m] = 2;
        end else begin
          m_err[m] = 0;
        end
        m_ref[m] = p;
      end
    end
    e_lock[m] = (m_st[m] == 2);
  endtask

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_dut(int m, string tag, int idx, int iv, int ill, int sq, int lk, int cnt);
    chk({tag, ".index"}, idx, e_idx[m]);
    chk({tag, ".index_valid"}, iv, e_iv[m]);
    chk({tag, ".illegal_code"}, ill, e_ill[m]);
    chk({tag, ".seq_error"}, sq, e_seq[m]);
    chk({tag, ".locked"}, lk, e_lock[m]);
    chk({tag, ".err_count"}, cnt, e_cnt[m]);
  endtask

  // Advance one clock: the model consumes the sample captured at the previous edge.
  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      if (rst) model_reset(m);
      else model_step(m, pend_valid, pend_code);
    end
    pend_code  = cur_code;
    pend_valid = rst ? 1'b0 : cur_valid;
    @(posedge clk);
    #1;
    chk_dut(0, "h", int'(bus_h.index), int'(bus_h.index_valid), int'(bus_h.illegal_code),
            int'(bus_h.seq_error), int'(bus_h.locked), int'(bus_h.err_count));
    chk_dut(1, "n", int'(bus_n.index), int'(bus_n.index_valid), int'(bus_n.illegal_code),
            int'(bus_n.seq_error), int'(bus_n.locked), int'(bus_n.err_count));
  endtask

  task automatic drive(logic [3:0] c, logic v);
    cur_code  = c;
    cur_valid = v;
    tick();
  endtask

  typedef struct {
    logic [3:0] code;
    logic       valid;
    int         idx;
    bit         iv;
    bit         ill;
    bit         sq;
    bit         lk;
  } vec_t;

  vec_t tbl[11];
  int   exp_err;

  initial begin
    // Expected fields: outputs after the row's edge (they reflect the previous row's sample).
    tbl[0]  = '{4'b0000, 1'b1, 0, 0, 0, 0, 0};
    tbl[1]  = '{4'b0001, 1'b1, 0, 1, 0, 0, 0};
    tbl[2]  = '{4'b0011, 1'b1, 1, 1, 0, 0, 0};
    tbl[3]  = '{4'b0111, 1'b1, 2, 1, 0, 0, 0};
    tbl[4]  = '{4'b1111, 1'b1, 3, 1, 0, 0, 1};
    tbl[5]  = '{4'b1110, 1'b1, 4, 1, 0, 0, 1};
    tbl[6]  = '{4'b1100, 1'b1, 5, 1, 0, 0, 1};
    tbl[7]  = '{4'b1000, 1'b1, 6, 1, 0, 0, 1};
    tbl[8]  = '{4'b0000, 1'b1, 7, 1, 0, 0, 1};
    tbl[9]  = '{4'b0001, 1'b0, 0, 1, 0, 0, 1};
    tbl[10] = '{4'b0000, 1'b0, 0, 0, 0, 0, 1};

    rst = 1'b1;
    drive(4'b0000, 1'b0);
    chk("reset.index", int'(bus_h.index), 0);
    chk("reset.locked", int'(bus_h.locked), 0);
    chk("reset.err_count", int'(bus_h.err_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].code, tbl[i].valid);
      chk($sformatf("tbl%0d.index", i), int'(bus_h.index), tbl[i].idx);
      chk($sformatf("tbl%0d.index_valid", i), int'(bus_h.index_valid), int'(tbl[i].iv));
      chk($sformatf("tbl%0d.illegal", i), int'(bus_h.illegal_code), int'(tbl[i].ill));
      chk($sformatf("tbl%0d.seq_error", i), int'(bus_h.seq_error), int'(tbl[i].sq));
      chk($sformatf("tbl%0d.locked", i), int'(bus_h.locked), int'(tbl[i].lk));
    end

    // Locked at 0: advance to 2, then an illegal code.
    drive(4'b0001, 1'b1);
    drive(4'b0011, 1'b1);
    drive(4'b0101, 1'b1);
    drive(4'b0000, 1'b0);
`ifdef JOHNSON_DECODER_ERR_COUNT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    chk("illegal.flag", int'(bus_h.illegal_code), 1);
    chk("illegal.no_seq", int'(bus_h.seq_error), 0);
    chk("illegal.index_held", int'(bus_h.index), 2);
    chk("illegal.err_count", int'(bus_h.err_count), exp_err);
    chk("illegal.still_locked", int'(bus_h.locked), 1);

    // Locked at 3, then two bad steps drop lock.
    drive(4'b0111, 1'b1);
    drive(4'b1100, 1'b1);
    drive(4'b0000, 1'b1);
    chk("seq1.flag", int'(bus_h.seq_error), 1);
    chk("seq1.locked", int'(bus_h.locked), 1);
    drive(4'b0000, 1'b0);
    chk("seq2.flag", int'(bus_h.seq_error), 1);
    chk("seq2.unlocked", int'(bus_h.locked), 0);
    chk("seq2.index", int'(bus_h.index), 0);

    // Relock ending at 0011, then repeat it.
    drive(4'b1000, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0001, 1'b1);
    drive(4'b0011, 1'b1);
    drive(4'b0011, 1'b1);
    chk("hold.locked_h", int'(bus_h.locked), 1);
    chk("hold.locked_n", int'(bus_n.locked), 1);
    drive(4'b0000, 1'b0);
    chk("hold.h_no_err", int'(bus_h.seq_error), 0);
    chk("hold.n_err", int'(bus_n.seq_error), 1);
    chk("hold.n_index", int'(bus_n.index), 2);

    // Reset in ACQUIRE with samples in flight.
    rst = 1'b1;
    drive(4'b0000, 1'b0);
    rst = 1'b0;
    drive(4'b0000, 1'b1);
    drive(4'b0001, 1'b1);
    drive(4'b0011, 1'b1);
    rst = 1'b1;
    drive(4'b0111, 1'b1);
    chk("midrst.index", int'(bus_h.index), 0);
    chk("midrst.iv", int'(bus_h.index_valid), 0);
    chk("midrst.locked", int'(bus_h.locked), 0);
    rst = 1'b0;
    drive(4'b0000, 1'b0);
    chk("midrst.no_stale", int'(bus_h.index_valid), 0);
    drive(4'b0000, 1'b0);
    chk("midrst.no_stale2", int'(bus_h.index_valid), 0);

    begin
      logic [3:0] bad_codes[8];
      int rp, r;
      bad_codes = '{4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1011, 4'b1101};
      rp = 0;
      for (int t = 0; t < 3000; t++) begin
        r = int'($urandom_range(0, 99));
        if (r < 60) begin
          rp = (rp + 1) % 8; drive(jcode(rp), 1'b1);
        end else if (r < 70) begin
          drive(jcode(rp), 1'b1);
        end else if (r < 78) begin
          rp = int'($urandom_range(0, 7)); drive(jcode(rp), 1'b1);
        end else if (r < 86) begin
          drive(bad_codes[$urandom_range(0, 7)], 1'b1);
        end else if (r < 99) begin
          drive(4'($urandom), 1'b0);
        end else begin
          rst = 1'b1; drive(jcode(rp), 1'b1); rst = 1'b0;
        end
      end
    end
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
